// File: rtl/pid_pkg.sv
// Shared constants, FSM state type and saturating helpers for the PID duty controller.
package pid_pkg;

  localparam logic [7:0] MODE_POSITION     = 8'd0;
  localparam logic [7:0] MODE_VELOCITY     = 8'd1;
  localparam logic [7:0] MODE_DISPLACEMENT = 8'd2;
  localparam logic [7:0] MODE_DIRECT       = 8'd3;

  localparam int ERR_W  = 26;
  localparam int PROD_W = 42;
  localparam int ACC_W  = 44;

  // Largest positive 24-bit signed value; also the hard cap on |duty|.
  localparam logic [23:0] DUTY_CAP = 24'h7FFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_PMUL,
    ST_IMUL,
    ST_DMUL,
    ST_SUM,
    ST_OUT
  } state_t;

  // Saturate a wide signed value into the 24-bit signed range.
  function automatic logic signed [23:0] sat24(input logic signed [47:0] v);
    logic signed [47:0] hi;
    logic signed [47:0] lo;
    hi = 48'sh7FFFFF;
    lo = -48'sh800000;
    if (v > hi) return 24'sh7FFFFF;
    else if (v < lo) return 24'sh800000;
    else return v[23:0];
  endfunction

  // Symmetric clamp of a wide signed value to +/-lim (lim is unsigned).
  function automatic logic signed [47:0] clamp_lim(input logic signed [47:0] v,
                                                    input logic [23:0] lim);
    logic signed [47:0] l;
    l = signed'({24'd0, lim});
    if (v > l) return l;
    else if (v < -l) return -l;
    else return v;
  endfunction

  // Cap a duty limit so the clamped duty always fits 24-bit signed.
  function automatic logic [23:0] cap_limit(input logic [23:0] lim);
    return (lim > DUTY_CAP) ? DUTY_CAP : lim;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate: acc <= (clear ? 0 : acc) + a*b when en.
module pid_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 26,
  parameter int P_W   = 42,
  parameter int ACC_W = 44
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = P_W'(a) * P_W'(b);
  assign prod_ext = ACC_W'(prod);

  // Accumulate one product per enabled cycle; clear restarts from this product.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/pid_duty_controller.sv
// PID duty controller: one tick -> snapshot inputs -> error -> three shared
// multiplies -> sum -> clamped duty, 6 cycles after the sampling edge.
// Tick handshake: update_tick is a 1-cycle strobe with no back-pressure; it is
// taken only when busy is low, otherwise it is dropped and overrun latches high.
module pid_duty_controller
  import pid_pkg::*;
#(
  parameter int OUT_SHIFT = 0,
  parameter int GAIN_W    = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        update_tick,
  input  logic [7:0]  control_mode,
  input  logic [23:0] setpoint,
  input  logic [23:0] Kp,
  input  logic [23:0] Ki,
  input  logic [23:0] Kd,
  input  logic [23:0] PWMLimit,
  input  logic [23:0] IntegralLimit,
  input  logic [23:0] deadband,
  input  logic [23:0] encoder0_position,
  input  logic [23:0] displacement,
  output logic [23:0] duty,
  output logic        duty_valid,
  output logic        busy,
  output logic        overrun
);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic mode_reset;
  logic pid_mode;

  // Snapshot taken at the accepted tick
  logic [7:0]                s_mode;
  logic signed [23:0]        s_sp;
  logic signed [GAIN_W-1:0]  s_kp;
  logic signed [GAIN_W-1:0]  s_ki;
  logic signed [GAIN_W-1:0]  s_kd;
  logic [23:0]               s_pwm_lim;
  logic [23:0]               s_int_lim;
  logic [23:0]               s_dead;
  logic signed [24:0]        s_fb;
  logic signed [24:0]        fb_now;

  // History kept across ticks
  logic [7:0]                mode_prev;
  logic                      seen_tick;
  logic signed [23:0]        enc0_prev;
  logic signed [ERR_W-1:0]   integ;
  logic signed [ERR_W-1:0]   err_prev;
  logic signed [ERR_W-1:0]   err_r;
  logic signed [ERR_W-1:0]   deriv_r;

  // Error-stage combinational terms
  logic signed [ERR_W-1:0]   diff;
  logic signed [23:0]        err_sat;
  logic signed [24:0]        err_ext;
  logic signed [24:0]        err_mag;
  logic                      in_dead;
  logic signed [ERR_W-1:0]   err_dz;
  logic signed [47:0]        integ_sum;
  logic signed [47:0]        integ_clamp;
  logic signed [ERR_W-1:0]   integ_nxt;
  logic signed [ERR_W-1:0]   deriv_nxt;

  // Shared multiplier and output stage
  logic                      mac_clear;
  logic                      mac_en;
  logic signed [GAIN_W-1:0]  mac_a;
  logic signed [ERR_W-1:0]   mac_b;
  logic signed [ACC_W-1:0]   mac_acc;
  logic signed [ACC_W-1:0]   sum_r;
  logic signed [47:0]        duty_calc;

  // Gain bits above GAIN_W are ignored by design.
  logic unused_gain_bits;
  assign unused_gain_bits = ^{Kp[23:GAIN_W], Ki[23:GAIN_W], Kd[23:GAIN_W]};

  assign accept     = update_tick && (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign pid_mode   = (s_mode <= MODE_DISPLACEMENT);
  assign mode_reset = !seen_tick || (control_mode != mode_prev)
                      || (control_mode > MODE_DISPLACEMENT);

  // Feedback selection from live inputs, captured with the snapshot.
  always_comb begin
    fb_now = '0;
    case (control_mode)
      MODE_POSITION:     fb_now = 25'($signed(encoder0_position));
      MODE_VELOCITY:     fb_now = 25'($signed(encoder0_position)) - 25'(enc0_prev);
      MODE_DISPLACEMENT: fb_now = 25'($signed(displacement));
      default:           fb_now = '0;
    endcase
  end

  // Error path: saturate, apply deadband, integrate with clamp, differentiate.
  always_comb begin
    diff        = ERR_W'(s_sp) - ERR_W'(s_fb);
    err_sat     = sat24(48'(diff));
    err_ext     = 25'(err_sat);
    err_mag     = err_ext[24] ? -err_ext : err_ext;
    in_dead     = ($unsigned(err_mag) <= {1'b0, s_dead});
    err_dz      = in_dead ? '0 : ERR_W'(err_sat);
    integ_sum   = 48'(integ) + 48'(err_dz);
    integ_clamp = clamp_lim(integ_sum, s_int_lim);
    integ_nxt   = integ_clamp[ERR_W-1:0];
    deriv_nxt   = err_dz - err_prev;
  end

  // Final duty: PID sum, direct setpoint or zero, clamped to the snapshot limit.
  always_comb begin
    duty_calc = '0;
    if (pid_mode) begin
      duty_calc = clamp_lim(48'(sum_r), cap_limit(s_pwm_lim));
    end else if (s_mode == MODE_DIRECT) begin
      duty_calc = clamp_lim(48'(s_sp), cap_limit(s_pwm_lim));
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and multiplier operand sequencing.
  always_comb begin
    state_nxt = state;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    mac_a     = s_kp;
    mac_b     = err_r;
    case (state)
      ST_IDLE: if (update_tick) state_nxt = ST_ERR;
      ST_ERR:  state_nxt = ST_PMUL;
      ST_PMUL: begin
        mac_clear = 1'b1;
        mac_en    = 1'b1;
        state_nxt = ST_IMUL;
      end
      ST_IMUL: begin
        mac_en    = 1'b1;
        mac_a     = s_ki;
        mac_b     = integ;
        state_nxt = ST_DMUL;
      end
      ST_DMUL: begin
        mac_en    = 1'b1;
        mac_a     = s_kd;
        mac_b     = deriv_r;
        state_nxt = ST_SUM;
      end
      ST_SUM:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  pid_mac #(
    .A_W   (GAIN_W),
    .B_W   (ERR_W),
    .P_W   (PROD_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .CLK   (CLK),
    .reset (reset),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (mac_a),
    .b     (mac_b),
    .acc   (mac_acc)
  );

  // Capture all inputs and feedback on an accepted tick.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s_mode    <= '0;
      s_sp      <= '0;
      s_kp      <= '0;
      s_ki      <= '0;
      s_kd      <= '0;
      s_pwm_lim <= '0;
      s_int_lim <= '0;
      s_dead    <= '0;
      s_fb      <= '0;
      enc0_prev <= '0;
      mode_prev <= '0;
      seen_tick <= 1'b0;
    end else if (accept) begin
      s_mode    <= control_mode;
      s_sp      <= setpoint;
      s_kp      <= Kp[GAIN_W-1:0];
      s_ki      <= Ki[GAIN_W-1:0];
      s_kd      <= Kd[GAIN_W-1:0];
      s_pwm_lim <= PWMLimit;
      s_int_lim <= IntegralLimit;
      s_dead    <= deadband;
      s_fb      <= fb_now;
      enc0_prev <= encoder0_position;
      mode_prev <= control_mode;
      seen_tick <= 1'b1;
    end
  end

  // Integrator and error history: cleared on mode change, updated in ERR.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      integ    <= '0;
      err_prev <= '0;
      err_r    <= '0;
      deriv_r  <= '0;
    end else begin
      if (accept && mode_reset) begin
        integ    <= '0;
        err_prev <= '0;
      end else if ((state == ST_ERR) && pid_mode) begin
        integ    <= integ_nxt;
        err_prev <= err_dz;
      end
      if (state == ST_ERR) begin
        err_r   <= err_dz;
        deriv_r <= deriv_nxt;
      end
    end
  end

  // Scaled sum, duty register, valid pulse and sticky overrun flag.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sum_r      <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (state == ST_SUM) sum_r <= mac_acc >>> OUT_SHIFT;
      if (state == ST_OUT) begin
        duty       <= duty_calc[23:0];
        duty_valid <= 1'b1;
      end
      if (update_tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

endmodule
